fxp_argmax_stream: RTL and testbench

//  Streaming signed fixed-point max/min tracker with arg index. Accepts a frame of
//  LEN Qm.Q samples over a valid/ready stream. Emits the extreme value and its position
//  in the frame. Used by the VAE datapath for activation range checks, pooling and
//  arg-selection. It replaces chains of single two-input comparators.

---
 rtl/fxp_argmax_stream.sv | 146 ++++++++++++++
 tb/tb_fxp_argmax_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_argmax_stream.sv
// fxp_argmax_stream
// Streaming signed max/min tracker. Consumes one frame of LEN two's complement
// samples over a valid/ready stream and reports the extreme sample together with
// its 0-based position in the frame. The first occurrence wins on ties.
// The Q parameter documents the fixed-point format only. The comparison works on raw
// two's complement words, so the binary point never matters.
module fxp_argmax_stream #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int LEN   = 8,
  parameter int IDX_W = ($clog2(LEN) > 1) ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  // Reject parameter sets the datapath cannot represent.
  if (LEN < 1 || N < 2 || Q < 0 || Q > N) begin : g_bad_params
    $error("fxp_argmax_stream: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic [N-1:0]     out_val_q, out_val_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic beat;
  logic win;

  // Signed greater-than: if the sign bits differ, the operand with the clear sign bit is larger.
  // Otherwise the magnitude bits compare as unsigned.
  function automatic logic signed_gt(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a[N-1] != b[N-1]) begin
      return b[N-1];
    end
    return (a[N-2:0] > b[N-2:0]);
  endfunction

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign out_val   = out_val_q;
  assign out_idx   = out_idx_q;
  assign beat      = in_valid && in_ready;

  // Next-state and datapath update; the frame mode is the one latched on beat 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    best_d    = best_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    out_val_d = out_val_q;
    out_idx_d = out_idx_q;
    win       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (beat) begin
          best_d = in_data;
          idx_d  = '0;
          cnt_d  = IDX_W'(1);
          mode_d = mode;
          if (LEN == 1) begin
            // A single-sample frame is its own result.
            state_d   = S_HOLD;
            out_val_d = in_data;
            out_idx_d = '0;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        if (beat) begin
          // A strict compare means an equal later sample never displaces the earlier one.
          win = mode_q ? signed_gt(best_q, in_data) : signed_gt(in_data, best_q);
          if (win) begin
            best_d = in_data;
            idx_d  = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_POS) begin
            state_d   = S_HOLD;
            cnt_d     = '0;
            out_val_d = win ? in_data : best_q;
            out_idx_d = win ? cnt_q : idx_q;
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any partial frame or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      out_val_q <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      out_val_q <= out_val_d;
      out_idx_q <= out_idx_d;
    end
  end

endmodule

// File: tb/tb_fxp_argmax_stream.sv
// Testbench for fxp_argmax_stream. Three instances (LEN = 8, 5, 1) share one clock.
// Each instance runs randomised frames against a reference model. The LEN=8 and
// LEN=1 instances then run directed scenarios. A scoreboard queue per instance is
// filled when a frame is issued and drained by a monitor at each result handshake.
`timescale 1ns/1ps
module tb_fxp_argmax_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: walk the frame and keep the first strictly better sample.
  function automatic void ref_model(input logic [15:0] s[8], input int l, input logic m,
                                    output logic [15:0] v, output int idx);
    v   = s[0];
    idx = 0;
    for (int k = 1; k < l; k++) begin
      if ((!m && ($signed(s[k]) > $signed(v))) || (m && ($signed(s[k]) < $signed(v)))) begin
        v   = s[k];
        idx = k;
      end
    end
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL L=%0d %s actual=%0h required=%0h", l, nm, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L  = (gi == 0) ? 8 : ((gi == 1) ? 5 : 1);
    localparam int IW = ($clog2(L) > 1) ? $clog2(L) : 1;

    logic          rst, mode, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0]   in_data, out_val;
    logic [IW-1:0] out_idx;
    logic [15:0]   exp_v[$];
    int            exp_i[$];
    logic [15:0]   fr[8];
    logic          rdy_rand;
    logic          phase1_done;
    logic          done;
    logic [15:0]   mon_v;
    int            mon_i;

    fxp_argmax_stream #(.N(16), .Q(12), .LEN(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_val   (out_val),
      .out_idx   (out_idx),
      .busy      (busy)
    );

    // Monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
        if (exp_v.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL L=%0d unexpected_result actual=%0h/%0d required=none", L, out_val, out_idx);
        end else begin
          mon_v = exp_v.pop_front();
          mon_i = exp_i.pop_front();
          chk("result_val", L, 32'(out_val), 32'(mon_v));
          chk("result_idx", L, 32'(out_idx), 32'(mon_i));
          $display("L=%0d result val=%h idx=%0d", L, out_val, out_idx);
        end
      end
    end

    // Random back-pressure when enabled.
    always @(posedge clk) begin
      if (rdy_rand) begin
        #1 out_ready = ($urandom_range(3) != 0);
      end
    end

    // Issue one frame from fr[], pushing its expected result first.
    task automatic send(input logic m, input int gap, input bit tog,
                        input bit use_c, input logic [15:0] cv, input int ci);
      logic [15:0] mv;
      int          mi;
      int          i;
      int          guard;
      bit          fire;
      ref_model(fr, L, m, mv, mi);
      if (use_c) begin
        mv = cv;
        mi = ci;
      end
      exp_v.push_back(mv);
      exp_i.push_back(mi);
      i     = 0;
      guard = 0;
      while (i < L && guard < 400) begin
        if ($urandom_range(99) < gap) begin
          in_valid = 1'b0;
          in_data  = 16'($urandom);
        end else begin
          in_valid = 1'b1;
          in_data  = fr[i];
        end
        mode = (i == 0) ? m : (tog ? ~m : m);
        @(negedge clk);
        fire = in_valid && in_ready;
        if (fire && i == L - 1) chk("valid_before_last", L, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        if (fire) i++;
        guard++;
      end
      in_valid = 1'b0;
      if (i < L) begin
        errors++;
        checks++;
        $display("FAIL L=%0d frame_timeout actual=%0d beats required=%0d", L, i, L);
      end else begin
        chk("valid_latency", L, 32'(out_valid), 32'd1);
      end
    endtask

    // Stop random back-pressure and wait (bounded) for all results to drain.
    task automatic drain();
      rdy_rand = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_v.size() != 0; k++) @(posedge clk);
      #1;
      chk("drain_empty", L, 32'(exp_v.size()), 32'd0);
    endtask

    // Reset, reset-state checks, then randomised frames with gaps and mode toggles.
    initial begin
      phase1_done = 1'b0;
      rdy_rand    = 1'b0;
      rst         = 1'b1;
      mode        = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", L, 32'(out_valid), 32'd0);
      chk("reset_busy", L, 32'(busy), 32'd0);
      chk("reset_in_ready", L, 32'(in_ready), 32'd1);
      chk("reset_out_val", L, 32'(out_val), 32'd0);
      chk("reset_out_idx", L, 32'(out_idx), 32'd0);
      @(posedge clk);
      #1 rdy_rand = 1'b1;
      for (int f = 0; f < 25; f++) begin
        for (int k = 0; k < 8; k++) begin
          case ($urandom_range(5))
            0:       fr[k] = 16'h8000;
            1:       fr[k] = 16'h7FFF;
            2:       fr[k] = 16'h0000;
            3:       fr[k] = 16'hFFFF;
            default: fr[k] = 16'($urandom);
          endcase
        end
        send(1'($urandom_range(1)), 40, 1'($urandom_range(1)), 1'b0, 16'h0, 0);
      end
      drain();
      phase1_done = 1'b1;
    end

    if (gi == 0) begin : g_dir
      // Directed: reference frames, back-pressure, and reset in mid-frame.
      initial begin
        done = 1'b0;
        wait (phase1_done);
        fr = '{16'hF000, 16'h1000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0800, 16'h7FFF, 16'hFFFF};
        send(1'b0, 0, 1'b0, 1'b1, 16'h7FFF, 2);
        send(1'b1, 0, 1'b0, 1'b1, 16'h8000, 3);
        fr = '{default: 16'h0C00};
        send(1'b0, 0, 1'b0, 1'b1, 16'h0C00, 0);
        drain();

        out_ready = 1'b0;
        fr = '{16'hF000, 16'h1000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0800, 16'h7FFF, 16'hFFFF};
        send(1'b0, 0, 1'b0, 1'b1, 16'h7FFF, 2);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp_out_valid", L, 32'(out_valid), 32'd1);
          chk("bp_out_val", L, 32'(out_val), 32'h7FFF);
          chk("bp_out_idx", L, 32'(out_idx), 32'd2);
          chk("bp_in_ready", L, 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_hs", L, 32'(in_ready), 32'd1);
        chk("out_valid_after_hs", L, 32'(out_valid), 32'd0);

        for (int k = 0; k < 4; k++) begin
          in_valid = 1'b1;
          in_data  = 16'($urandom);
          mode     = 1'b0;
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
        chk("busy_mid_frame", L, 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", L, 32'(out_valid), 32'd0);
        chk("rst_busy", L, 32'(busy), 32'd0);
        chk("rst_out_val", L, 32'(out_val), 32'd0);
        chk("rst_out_idx", L, 32'(out_idx), 32'd0);
        for (int k = 0; k < 8; k++) fr[k] = 16'($urandom);
        send(1'b1, 0, 1'b0, 1'b0, 16'h0, 0);
        drain();
        done = 1'b1;
      end
    end else if (gi == 2) begin : g_len1
      // Directed: back-to-back single-sample frames alternate beat and bubble.
      initial begin
        done = 1'b0;
        wait (phase1_done);
        for (int k = 0; k < 12; k++) begin
          in_valid = 1'b1;
          in_data  = 16'($urandom);
          mode     = 1'($urandom_range(1));
          @(negedge clk);
          chk("bubble_in_ready", L, 32'(in_ready), ((k % 2) == 0) ? 32'd1 : 32'd0);
          if (in_valid && in_ready) begin
            exp_v.push_back(in_data);
            exp_i.push_back(0);
          end
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
        drain();
        done = 1'b1;
      end
    end else begin : g_plain
      initial begin
        done = 1'b0;
        wait (phase1_done);
        done = 1'b1;
      end
    end
  end

  // Global completion with a hard cycle budget.
  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int k = 0; k < 20000 && !all_done; k++) begin
      @(posedge clk);
      all_done = (g_inst[0].done === 1'b1) && (g_inst[1].done === 1'b1) && (g_inst[2].done === 1'b1);
    end
    if (!all_done) begin
      errors++;
      checks++;
      $display("FAIL global_timeout actual=not_done required=done");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
